// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   - FSM state encoding
//   - double-dabble adjust constants
//   - digit value shown on overflow
package bin_to_bcd_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ        = 4'd3;
    localparam logic [3:0] BCD_OVF_DIGIT  = 4'hF;

endpackage

// File: rtl/bin_to_bcd_seq_bcd_add3.sv
// Double-dabble digit adjust: adds 3 to a BCD digit that is 5 or more so that
// the following left shift carries correctly into the next decade.
//   i_digit : scratch BCD digit before the shift
//   o_digit : adjusted digit
module bcd_add3
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= BCD_ADJ_THRESH) ? (i_digit + BCD_ADJ) : i_digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential (double-dabble) binary-to-BCD converter, one input bit per clock.
// Produces packed BCD digits plus a leading-zero blank mask for the display.
//   i_clk      : system clock
//   i_rst      : synchronous active-high reset (aborts a conversion)
//   i_start    : conversion request, honoured only in IDLE
//   i_bin      : binary value captured on the accepting edge
//   o_busy     : conversion in progress
//   o_done     : one-cycle pulse when a new result is latched
//   o_bcd      : packed BCD, o_bcd[3:0] is the rightmost digit
//   o_blank    : leading-zero mask, 1 = digit off (bit 0 never blanked)
//   o_overflow : value needed more than DIGITS digits
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [WIDTH-1:0]      i_bin,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic [DIGITS-1:0]     o_blank,
    output logic                  o_overflow
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    // Reset mask shows a single "0" in the rightmost position.
    localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

    state_t              r_state, w_next;
    logic [WIDTH-1:0]    r_shift;
    logic [BW-1:0]       r_scratch;
    logic [BW-1:0]       w_adj;
    logic                r_ovf_sticky;
    logic [CW-1:0]       r_cnt;
    logic                r_busy, r_done, r_overflow;
    logic [BW-1:0]       r_bcd;
    logic [DIGITS-1:0]   r_blank;
    logic [DIGITS-1:0]   w_blank;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            bcd_add3 u_add3 (
                .i_digit (r_scratch[4*g +: 4]),
                .o_digit (w_adj[4*g +: 4])
            );
        end
    endgenerate

    // Digit i blanks when it and every digit above it are zero.
    always_comb begin
        logic w_zero_above;
        w_blank      = '0;
        w_zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_zero_above = w_zero_above & (r_scratch[4*i +: 4] == 4'd0);
            w_blank[i]   = w_zero_above;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (i_start) w_next = ST_SHIFT;
            ST_SHIFT: if (r_cnt == CW'(1)) w_next = ST_LATCH;
            ST_LATCH: w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shift      <= '0;
            r_scratch    <= '0;
            r_ovf_sticky <= 1'b0;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_bcd        <= '0;
            r_blank      <= BLANK_RST;
            r_overflow   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_shift      <= i_bin;
                        r_scratch    <= '0;
                        r_ovf_sticky <= 1'b0;
                        r_cnt        <= CW'(WIDTH);
                        r_busy       <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    // Any 1 leaving the top digit means the partial value
                    // reached 10^DIGITS; later digits are then meaningless.
                    r_scratch    <= {w_adj[BW-2:0], r_shift[WIDTH-1]};
                    r_shift      <= r_shift << 1;
                    r_ovf_sticky <= r_ovf_sticky | w_adj[BW-1];
                    r_cnt        <= r_cnt - CW'(1);
                end
                ST_LATCH: begin
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_overflow <= r_ovf_sticky;
                    if (r_ovf_sticky) begin
                        r_bcd   <= {DIGITS{BCD_OVF_DIGIT}};
                        r_blank <= '0;
                    end else begin
                        r_bcd   <= r_scratch;
                        r_blank <= w_blank;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_bcd      = r_bcd;
    assign o_blank    = r_blank;
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;

    typedef struct {
        logic [31:0] bcd8;
        logic [7:0]  blank8;
        logic        ovf8;
        logic [15:0] bcd4;
        logic [3:0]  blank4;
        logic        ovf4;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [15:0] bin;
    logic        d8_busy, d8_done, d8_ovf;
    logic [31:0] d8_bcd;
    logic [7:0]  d8_blank;
    logic        d4_busy, d4_done, d4_ovf;
    logic [15:0] d4_bcd;
    logic [3:0]  d4_blank;

    exp_t q8[$];
    exp_t q4[$];
    exp_t m8_e, m4_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.WIDTH(16), .DIGITS(8)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_bin(bin),
        .o_busy(d8_busy), .o_done(d8_done), .o_bcd(d8_bcd),
        .o_blank(d8_blank), .o_overflow(d8_ovf)
    );

    bin_to_bcd_seq #(.WIDTH(16), .DIGITS(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_bin(bin),
        .o_busy(d4_busy), .o_done(d4_done), .o_bcd(d4_bcd),
        .o_blank(d4_blank), .o_overflow(d4_ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] b8, input logic [7:0] bl8, input logic o8,
                        input logic [15:0] b4, input logic [3:0] bl4, input logic o4);
        exp_t e;
        e.bcd8 = b8; e.blank8 = bl8; e.ovf8 = o8;
        e.bcd4 = b4; e.blank4 = bl4; e.ovf4 = o4;
        q8.push_back(e);
        q4.push_back(e);
    endtask

    // Scoreboard monitors: pop one expectation per done pulse.
    always @(negedge clk) begin
        if (!rst && d8_done) begin
            if (q8.size() == 0) begin
                chk("d8_unexpected_done", 32'd1, 32'd0);
            end else begin
                m8_e = q8.pop_front();
                chk("d8_bcd", d8_bcd, m8_e.bcd8);
                chk("d8_blank", {24'd0, d8_blank}, {24'd0, m8_e.blank8});
                chk("d8_overflow", {31'd0, d8_ovf}, {31'd0, m8_e.ovf8});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && d4_done) begin
            if (q4.size() == 0) begin
                chk("d4_unexpected_done", 32'd1, 32'd0);
            end else begin
                m4_e = q4.pop_front();
                chk("d4_bcd", {16'd0, d4_bcd}, {16'd0, m4_e.bcd4});
                chk("d4_blank", {28'd0, d4_blank}, {28'd0, m4_e.blank4});
                chk("d4_overflow", {31'd0, d4_ovf}, {31'd0, m4_e.ovf4});
            end
        end
    end

    // Single-pulse conversion with latency and handshake checks.
    task automatic run(input logic [15:0] b);
        int  n, nb;
        bit  seen;
        @(posedge clk); #1; start = 1'b1; bin = b;
        @(posedge clk); #1; start = 1'b0;          // E0 has passed
        n = 0; nb = 0; seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (d8_done) seen = 1'b1;
            else if (d8_busy) nb++;
        end
        chk("done_latency", 32'(n), 32'd18);
        chk("busy_cycles", 32'(nb), 32'd17);
        @(negedge clk);
        chk("done_one_cycle", {31'd0, d8_done}, 32'd0);
    endtask

    initial begin
        int nd;
        int d_at [2];
        rst = 1'b1; start = 1'b0; bin = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'd0, d8_busy}, 32'd0);
        chk("rst_done", {31'd0, d8_done}, 32'd0);
        chk("rst_bcd", d8_bcd, 32'd0);
        chk("rst_blank8", {24'd0, d8_blank}, 32'hFE);
        chk("rst_overflow", {31'd0, d8_ovf}, 32'd0);
        chk("rst_blank4", {28'd0, d4_blank}, 32'hE);

        push(32'h00000000, 8'hFE, 1'b0, 16'h0000, 4'hE, 1'b0); run(16'd0);
        push(32'h00065535, 8'hE0, 1'b0, 16'hFFFF, 4'h0, 1'b1); run(16'd65535);
        push(32'h00009999, 8'hF0, 1'b0, 16'h9999, 4'h0, 1'b0); run(16'd9999);
        push(32'h00010000, 8'hE0, 1'b0, 16'hFFFF, 4'h0, 1'b1); run(16'd10000);

        // Start held high; bin changes after capture.
        push(32'h00001234, 8'hF0, 1'b0, 16'h1234, 4'h0, 1'b0);
        push(32'h00000999, 8'hF8, 1'b0, 16'h0999, 4'h8, 1'b0);
        @(posedge clk); #1; start = 1'b1; bin = 16'd1234;
        @(posedge clk);                             // E0
        nd = 0; d_at[0] = 0; d_at[1] = 0;
        for (int k = 1; k <= 60 && nd < 2; k++) begin
            @(posedge clk); #1;
            if (k == 3) bin = 16'd999;
            if (d8_done) begin
                d_at[nd] = k;
                nd++;
                if (nd == 2) start = 1'b0;
            end
        end
        start = 1'b0;
        chk("held_done_count", 32'(nd), 32'd2);
        chk("held_first_done", 32'(d_at[0]), 32'd17);
        chk("held_done_spacing", 32'(d_at[1] - d_at[0]), 32'd18);

        // Reset during a conversion aborts it.
        @(posedge clk); #1; start = 1'b1; bin = 16'd12345;
        @(posedge clk); #1; start = 1'b0;          // E0
        repeat (4) @(posedge clk);                  // E0+4
        #1 rst = 1'b1;
        @(posedge clk);                             // E0+5
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, d8_busy}, 32'd0);
        chk("abort_done", {31'd0, d8_done}, 32'd0);
        chk("abort_bcd", d8_bcd, 32'd0);
        chk("abort_blank8", {24'd0, d8_blank}, 32'hFE);
        chk("abort_blank4", {28'd0, d4_blank}, 32'hE);
        nd = 0;
        repeat (30) begin
            @(negedge clk);
            if (d8_done || d4_done) nd++;
        end
        chk("abort_no_done", 32'(nd), 32'd0);
        push(32'h00000042, 8'hFC, 1'b0, 16'h0042, 4'hC, 1'b0); run(16'd42);

        // Starts during SHIFT and LATCH are ignored.
        push(32'h00000777, 8'hF8, 1'b0, 16'h0777, 4'h8, 1'b0);
        @(posedge clk); #1; start = 1'b1; bin = 16'd777;
        @(posedge clk); #1; start = 1'b0;          // E0
        nd = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (d8_done) nd++;
            if (k == 3)  begin start = 1'b1; bin = 16'd5; end
            if (k == 4)  start = 1'b0;
            if (k == 16) begin start = 1'b1; bin = 16'd6; end
            if (k == 17) start = 1'b0;
        end
        chk("ignore_done_count", 32'(nd), 32'd1);

        repeat (5) @(negedge clk);
        chk("q8_drained", 32'(q8.size()), 32'd0);
        chk("q4_drained", 32'(q4.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
